// File: rtl/axis_fifo_pkt.sv
// axis_fifo_pkt: AXI-Stream FIFO with tkeep/tuser sideband, occupancy count
// and an optional store-and-forward packet mode that drops oversize packets.
//
// Ports:
//   aclk, areset        clock (rising edge), asynchronous active-high reset
//   s_axis_*            slave side: tdata/tkeep/tuser/tlast/tvalid in, tready out
//   m_axis_*            master side: tdata/tkeep/tuser/tlast/tvalid out, tready in
//   count               entries held, including uncommitted packet beats
//   pkt_drop            one-cycle pulse when an oversize packet is discarded
//
// The master-side registers always mirror the head entry mem[rd_ptr]. rd_ptr
// only advances on a master handshake, so the presented beat is still counted
// in the FIFO and cannot be overwritten while it waits for tready.
module axis_fifo_pkt #(
    parameter int DATA_WIDTH  = 16,
    parameter int USER_WIDTH  = 1,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic [USER_WIDTH-1:0]       s_axis_tuser,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [USER_WIDTH-1:0]       m_axis_tuser,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        pkt_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int KW = DATA_WIDTH / 8;
    localparam int EW = 1 + USER_WIDTH + KW + DATA_WIDTH;
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [AW:0] ptr_t;
    typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

    logic [EW-1:0] mem_q [DEPTH];

    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   wr_commit_q, wr_commit_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    state_t state_q, state_d;
    logic   live_q;        // holds tready low until the first edge after reset
    logic   m_vld_q, m_vld_d;
    logic   [EW-1:0] m_beat_q;
    logic   [CW-1:0] count_q;
    logic   drop_q, drop_d;

    logic   full, s_fire, wr_en, rd_fire;

    assign full    = (ptr_t'(wr_ptr_q - rd_ptr_q) == ptr_t'(DEPTH));
    assign s_fire  = s_axis_tvalid && s_axis_tready;
    assign rd_fire = m_vld_q && m_axis_tready;

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: only packet mode ever leaves IDLE
    always_comb begin
        state_d = state_q;
        if (PACKET_MODE != 0 && s_fire) begin
            case (state_q)
                IDLE:    if (!s_axis_tlast) state_d = PKT;
                PKT: begin
                    if (s_axis_tlast)
                        state_d = IDLE;
                    // this beat makes the partial packet occupy every entry
                    else if (ptr_t'(wr_ptr_q - wr_commit_q) == ptr_t'(DEPTH - 1))
                        state_d = DROP;
                end
                DROP:    if (s_axis_tlast) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: DROP swallows beats regardless of occupancy
    always_comb begin
        s_axis_tready = live_q && (state_q == DROP || !full);
        wr_en         = s_fire && (state_q != DROP);
        drop_d        = s_fire && (state_q == DROP) && s_axis_tlast;
    end

    // Pointer next-state and master-side view
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        if (drop_d) begin
            wr_ptr_d = wr_commit_q;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (PACKET_MODE == 0 || s_axis_tlast)
                wr_commit_d = wr_ptr_q + ptr_t'(1);
        end
        rd_ptr_d = rd_ptr_q + ptr_t'(rd_fire);
        // Uses the old commit pointer: a beat becomes visible one edge after
        // it is written, and the memory read below is already settled.
        m_vld_d  = (wr_commit_q != rd_ptr_d);
    end

    always_ff @(posedge aclk) begin
        if (wr_en)
            mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            live_q      <= 1'b0;
            m_vld_q     <= 1'b0;
            m_beat_q    <= '0;
            count_q     <= '0;
            drop_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            live_q      <= 1'b1;
            m_vld_q     <= m_vld_d;
            m_beat_q    <= mem_q[rd_ptr_d[AW-1:0]];
            count_q     <= CW'(ptr_t'(wr_ptr_d - rd_ptr_d));
            drop_q      <= drop_d;
        end
    end

    assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = m_beat_q;
    assign m_axis_tvalid = m_vld_q;
    assign count         = count_q;
    assign pkt_drop      = drop_q;

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Bench for axis_fifo_pkt: one cut-through instance (DEPTH=16) and one
// packet-mode instance (DEPTH=8) share the stimulus; sel picks the active one.
module tb_axis_fifo_pkt;
    localparam int DW = 16, UW = 1, KW = 2, CT_D = 16, PK_D = 8;

    logic aclk = 1'b0, areset = 1'b0;
    always #5 aclk = ~aclk;

    logic          sel;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [UW-1:0] s_tuser;
    logic          s_tlast, s_tvalid;
    logic          m_fix, m_rnd, mr_rand, m_ready;
    assign m_ready = mr_rand ? m_rnd : m_fix;

    logic          ct_s_ready, ct_m_last, ct_m_valid, ct_drop;
    logic [DW-1:0] ct_m_data;
    logic [KW-1:0] ct_m_keep;
    logic [UW-1:0] ct_m_user;
    logic [4:0]    ct_count;
    logic          pk_s_ready, pk_m_last, pk_m_valid, pk_drop;
    logic [DW-1:0] pk_m_data;
    logic [KW-1:0] pk_m_keep;
    logic [UW-1:0] pk_m_user;
    logic [3:0]    pk_count;

    axis_fifo_pkt #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(CT_D), .PACKET_MODE(0)) u_ct (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid && !sel), .s_axis_tready(ct_s_ready),
        .m_axis_tdata(ct_m_data), .m_axis_tkeep(ct_m_keep), .m_axis_tuser(ct_m_user),
        .m_axis_tlast(ct_m_last), .m_axis_tvalid(ct_m_valid), .m_axis_tready(m_ready && !sel),
        .count(ct_count), .pkt_drop(ct_drop));

    axis_fifo_pkt #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(PK_D), .PACKET_MODE(1)) u_pk (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid && sel), .s_axis_tready(pk_s_ready),
        .m_axis_tdata(pk_m_data), .m_axis_tkeep(pk_m_keep), .m_axis_tuser(pk_m_user),
        .m_axis_tlast(pk_m_last), .m_axis_tvalid(pk_m_valid), .m_axis_tready(m_ready && sel),
        .count(pk_count), .pkt_drop(pk_drop));

    logic          s_ready, m_last, m_valid, pkt_drop;
    logic [DW-1:0] m_data;
    logic [KW-1:0] m_keep;
    logic [UW-1:0] m_user;
    logic [4:0]    count;
    assign s_ready  = sel ? pk_s_ready : ct_s_ready;
    assign m_data   = sel ? pk_m_data  : ct_m_data;
    assign m_keep   = sel ? pk_m_keep  : ct_m_keep;
    assign m_user   = sel ? pk_m_user  : ct_m_user;
    assign m_last   = sel ? pk_m_last  : ct_m_last;
    assign m_valid  = sel ? pk_m_valid : ct_m_valid;
    assign pkt_drop = sel ? pk_drop    : ct_drop;
    assign count    = sel ? {1'b0, pk_count} : ct_count;

    int n_chk = 0, n_err = 0, n_drops = 0, exp_drops = 0;
    logic [19:0] exp_q[$];   // beat = {last, user, keep, data}

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge aclk) begin
        #1 m_rnd = 1'($urandom_range(0, 1));
    end

    // Scoreboard: ordered compare on every master handshake plus hold rules
    logic        prev_stall = 1'b0;
    logic [19:0] prev_beat, cur, expb;
    always @(negedge aclk) begin
        if (areset) prev_stall = 1'b0;
        else begin
            cur = {m_last, m_user, m_keep, m_data};
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_beat", cur, prev_beat);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("spurious_beat", m_valid, 0);
                else begin
                    expb = exp_q.pop_front();
                    chk("out_beat", cur, expb);
                end
            end
            if (pkt_drop) n_drops++;
            prev_stall = m_valid && !m_ready;
            prev_beat  = cur;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [19:0] b, output int waits);
        bit acc = 0;
        {s_tlast, s_tuser, s_tkeep, s_tdata} = b;
        s_tvalid = 1'b1;
        waits = 0;
        while (!acc && waits < 200) begin
            @(negedge aclk);
            acc = s_ready;
            @(posedge aclk);
            #1;
            if (!acc) waits++;
        end
        s_tvalid = 1'b0;
        chk("tready_timeout", acc, 1);
    endtask

    // Reference: cut-through forwards every beat; packet mode forwards whole
    // packets of at most PK_D beats and drops longer ones.
    task automatic send_pkt(input int len, input bit incr, input bit gaps);
        logic [19:0] pk[$];
        logic [19:0] b;
        int w;
        for (int i = 0; i < len; i++) begin
            b[15:0]  = incr ? 16'(i + 1) : 16'($urandom);
            b[17:16] = incr ? 2'b11 : 2'($urandom);
            b[18]    = incr ? 1'b0 : 1'($urandom);
            b[19]    = (i == len - 1);
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge aclk);
                #1;
            end
            send_beat(b, w);
            if (sel && len > PK_D) chk("ovs_tready", w, 0);
            if (!sel) exp_q.push_back(b);
            else pk.push_back(b);
        end
        if (sel) begin
            if (len > PK_D) exp_drops++;
            else foreach (pk[i]) exp_q.push_back(pk[i]);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge aclk);
            n++;
        end
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1;
        #1;
        chk("rst_tready", s_ready, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", {m_user, m_keep, m_data}, 0);
        chk("rst_count", count, 0);
        chk("rst_drop", pkt_drop, 0);
        exp_q.delete();
        @(negedge aclk);
        areset = 1'b0;
        #1;
        chk("rst_hold_tready", s_ready, 0);
        @(posedge aclk);
        #1;
        chk("rst_rel_tready", s_ready, 1);
    endtask

    initial begin
        int w;
        logic [19:0] b;
        logic [19:0] pk4[$];
        sel = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = 1'b0;
        m_fix = 1'b0; mr_rand = 1'b0;
        do_reset();

        // Cut-through: fill to DEPTH, then drain one per cycle
        send_pkt(16, 1, 0);
        @(negedge aclk);
        chk("ct_full_count", count, 16);
        chk("ct_full_tready", s_ready, 0);
        @(posedge aclk);
        #1 m_fix = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge aclk);
            chk("ct_drain_count", count, 16 - k);
        end
        @(posedge aclk);
        #1 m_fix = 1'b0;

        // Cut-through latency from empty
        b = {1'b1, 1'b1, 2'b11, 16'hABCD};
        send_beat(b, w);
        exp_q.push_back(b);
        chk("lat_edge_n_valid", m_valid, 0);
        @(posedge aclk);
        #1;
        chk("lat_valid", m_valid, 1);
        chk("lat_data", m_data, 16'hABCD);
        chk("lat_keep", m_keep, 2'b11);
        chk("lat_user", m_user, 1);
        m_fix = 1'b1;
        wait_drain();

        mr_rand = 1'b1;
        repeat (100) send_pkt($urandom_range(1, CT_D), 0, 1);
        wait_drain();
        mr_rand = 1'b0;

        // Packet mode
        sel = 1'b1;
        m_fix = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            b = {1'(i == 3), 1'($urandom), 2'($urandom), 16'($urandom)};
            send_beat(b, w);
            pk4.push_back(b);
            chk("pk_wait_valid", m_valid, 0);
        end
        foreach (pk4[i]) exp_q.push_back(pk4[i]);
        @(posedge aclk);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("pk_stream_valid", m_valid, 1);
            chk("pk_stream_last", m_last, (i == 3));
        end
        wait_drain();

        // Oversize packet
        send_pkt(12, 0, 0);
        chk("ovs_drop", pkt_drop, 1);
        chk("ovs_count", count, 0);
        chk("ovs_no_out", m_valid, 0);
        @(posedge aclk);
        #1;
        chk("ovs_drop_clr", pkt_drop, 0);
        send_pkt(2, 0, 0);
        wait_drain();

        // Random backpressure, packets never exceed DEPTH
        mr_rand = 1'b1;
        repeat (1000) send_pkt($urandom_range(1, PK_D), 0, 1);
        wait_drain();
        mr_rand = 1'b0;
        m_fix = 1'b1;
        chk("drop_count", n_drops, exp_drops);

        // Reset in the middle of a packet
        for (int i = 0; i < 3; i++) begin
            b = {1'b0, 1'b0, 2'b11, 16'(16'h5000 + i)};
            send_beat(b, w);
        end
        do_reset();
        send_pkt(5, 0, 0);
        wait_drain();
        chk("final_drop_count", n_drops, exp_drops);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
